enc4to2_seq: RTL and testbench

ENC4TO2_SEQ -- requirements
Module: enc4to2_seq

---
 rtl/enc4to2_pkg.sv | 17 +
 rtl/prio_enc4.sv | 23 ++
 rtl/enc4to2_seq.sv | 101 ++++++++++
 tb/tb_enc4to2_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/enc4to2_pkg.sv
// Shared constants and state encoding for the sequential 4-to-2 priority encoder.
// The ZERO state exists only when ENC_ZERO_FLAG_EN is defined.
package enc4to2_pkg;

  localparam int VEC_W  = 4;
  localparam int CODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1
`ifdef ENC_ZERO_FLAG_EN
    ,
    ST_ZERO = 2'd2
`endif
  } state_e;

endpackage : enc4to2_pkg

// File: rtl/prio_enc4.sv
// Combinational priority encoder: highest set index (bit 3 wins), nonzero flag
// and exactly-one-bit flag for a 4-bit vector.
module prio_enc4
  import enc4to2_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic              single
);

  always_comb begin
    idx = '0;
    // Ascending scan so the last hit, i.e. the highest index, wins.
    for (int i = 0; i < VEC_W; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - VEC_W'(1))) == '0);

endmodule : prio_enc4

// File: rtl/enc4to2_seq.sv
// Sequential 4-to-2 encoder: accepts a multi-hot vector and emits one beat per
// set bit, highest index first. Define ENC_ZERO_FLAG_EN to report zero vectors.
module enc4to2_seq
  import enc4to2_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vec,
  input  logic              en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last
`ifdef ENC_ZERO_FLAG_EN
  ,
  output logic              out_zero
`endif
);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   pending_q, pending_d;
  logic [CODE_W-1:0]  top_idx;
  logic               pend_any;
  logic               pend_single;

  prio_enc4 u_prio (
    .vec    (pending_q),
    .idx    (top_idx),
    .any    (pend_any),
    .single (pend_single)
  );

  // Outputs depend only on registered state, so in_valid/in_vec never reach them
  // combinationally.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    pending_d = pending_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_code  = '0;
    out_last  = 1'b0;
`ifdef ENC_ZERO_FLAG_EN
    out_zero  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // A disabled vector is consumed but leaves nothing pending.
          pending_d = en ? in_vec : '0;
          if (en && (in_vec != '0)) begin
            state_d = ST_EMIT;
          end
`ifdef ENC_ZERO_FLAG_EN
          else if (en) begin
            state_d = ST_ZERO;
          end
`endif
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_code  = top_idx;
        out_last  = pend_single;
        if (out_ready) begin
          pending_d = pending_q & ~(VEC_W'(1) << top_idx);
          if (pend_single) state_d = ST_IDLE;
        end
      end
`ifdef ENC_ZERO_FLAG_EN
      ST_ZERO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_zero  = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule : enc4to2_seq

// File: tb/tb_enc4to2_seq.sv
// Self-checking bench for enc4to2_seq: directed cases plus randomized vectors
// against a beat-list reference model. Honours ENC_ZERO_FLAG_EN.
module tb_enc4to2_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_vec;
  logic       en;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_code;
  logic       out_last;
  logic       zero_obs;
`ifdef ENC_ZERO_FLAG_EN
  logic       out_zero;
  assign zero_obs = out_zero;
`else
  assign zero_obs = 1'b0;
`endif

  enc4to2_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last)
`ifdef ENC_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int last;
    int zero;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat list: one beat per set bit, descending, last on the final one.
  function automatic void build_model(input logic [3:0] vec, input logic e);
    int n, k;
    beat_t b;
    exp_q.delete();
    if (!e) return;
    if (vec == 4'd0) begin
`ifdef ENC_ZERO_FLAG_EN
      b.code = 0; b.last = 1; b.zero = 1;
      exp_q.push_back(b);
`endif
      return;
    end
    n = $countones(vec);
    k = 0;
    for (int i = 3; i >= 0; i--) begin
      if (vec[i]) begin
        k++;
        b.code = i; b.last = (k == n) ? 1 : 0; b.zero = 0;
        exp_q.push_back(b);
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [3:0] vec, input logic e);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    build_model(vec, e);
    in_valid = 1'b1;
    in_vec   = vec;
    en       = e;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = 4'($urandom);
    en       = 1'($urandom);
  endtask

  // Consume expected beats; out_ready held low for 'hold' cycles, then high with
  // probability prob%. Spurious in_valid traffic is injected while busy.
  task automatic drain(input int hold, input int prob);
    int   cyc = 0;
    logic rdy;
    while (exp_q.size() > 0 && cyc < 200) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("out_code", 32'(out_code), 32'(exp_q[0].code));
      check("out_last", 32'(out_last), 32'(exp_q[0].last));
      check("out_zero", 32'(zero_obs), 32'(exp_q[0].zero));
      rdy       = (cyc >= hold) && ($urandom_range(99) < prob);
      out_ready = rdy;
      in_valid  = !(rdy && exp_q.size() == 1) && 1'($urandom);
      in_vec    = 4'($urandom);
      en        = 1'($urandom);
      if (rdy) void'(exp_q.pop_front());
      cyc++;
      @(negedge clk);
    end
    if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("done_out_valid", 32'(out_valid), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 4'd0;
    en        = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_code", 32'(out_code), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_zero", 32'(zero_obs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two beats, no backpressure.
    send(4'b1010, 1'b1);
    drain(0, 100);

    // All four lines, stalled for three cycles first.
    send(4'b1111, 1'b1);
    drain(3, 100);

    // Disabled vector is dropped.
    send(4'b0001, 1'b0);
    drain(0, 100);
    @(negedge clk);
    check("en0_idle_out_valid", 32'(out_valid), 32'd0);

    // Zero vector with enable: one zero beat or nothing, depending on build.
    send(4'b0000, 1'b1);
    drain(0, 100);

    // Reset in the middle of emission drops remaining beats.
    send(4'b0110, 1'b1);
    check("rst_mid_code0", 32'(out_code), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rst_mid_code1", 32'(out_code), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_code", 32'(out_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
    end

    // Randomized vectors, enables and backpressure.
    for (int t = 0; t < 150; t++) begin
      send(4'($urandom), $urandom_range(3) != 0);
      drain($urandom_range(2), $urandom_range(100, 30));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_enc4to2_seq
